mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single data/instruction memory port between the fetch stage and the MEM stage, and sequences double-word loads and stores (LDW/SDW, op codes 8/9 with even rd) as two back-to-back word beats that cannot be split. It sits between the pipeline stages and the memory, and generates the fetch and MEM stall signals consumed by the hazard logic. A saturating starvation counter guarantees fetch progress under sustained MEM traffic.

## Interface
- ADDR_W, 32, address width (word addressed)
- DATA_W, 32, data word width
- STARVE_LIM, 4, consecutive denied fetch cycles before fetch is forced to win (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch requests port this cycle
- if_addr  in  ADDR_W  fetch address
- if_grant  out  1  fetch owns port this cycle (combinational)
- mem_req  in  1  MEM stage request; held until mem_done
- mem_we  in  1  1 = store, 0 = load; held with mem_req
- mem_double  in  1  double-word transfer; held with mem_req
- mem_addr  in  ADDR_W  base word address; held with mem_req
- mem_wdata  in  DATA_W  store data for the beat indicated by mem_beat
- mem_beat  out  1  registered beat index (0 = base, 1 = base+1)
- mem_grant  out  1  a MEM beat is on the port this cycle
- mem_done  out  1  last beat of the MEM transfer is on the port this cycle
- mem_rdata_lo  out  DATA_W  registered beat-0 load data
- mem_rdata_hi  out  DATA_W  registered beat-1 load data (double loads only)
- mem_rvalid  out  1  one-cycle pulse: load data registers valid
- stall_if  out  1  if_req & ~if_grant
- stall_mem  out  1  mem_req & ~mem_done
- port_en, port_we  out  1  memory enable / write enable
- port_addr  out  ADDR_W  memory address
- port_wdata  out  DATA_W  memory write data
- port_rdata  in  DATA_W  memory read data, combinational (same cycle as port_addr)

## Operation
- States: IDLE, DBL (second beat pending). Registers: state, mem_beat, base address latch, starve_cnt (0..STARVE_LIM, saturating), rdata_lo, rdata_hi, mem_rvalid.
- IDLE arbitration: force_if = if_req & (starve_cnt == STARVE_LIM).
  - mem_req & ~force_if: MEM beat 0; port_addr = mem_addr, port_we = mem_we, port_wdata = mem_wdata. If mem_double: latch mem_addr+1 (mod 2^ADDR_W), go to DBL, mem_beat←1, mem_done=0. Else mem_done=1, stay IDLE.
  - else if if_req: if_grant=1, port_addr = if_addr, port_we=0.
  - else port_en=0.
- DBL: MEM beat 1 granted unconditionally; port_addr = latched address; mem_done=1; fetch denied regardless of starve_cnt; next IDLE, mem_beat←0. mem_req/mem_we are not re-checked in DBL.
- starve_cnt: cleared when if_grant or ~if_req; else incremented, saturating at STARVE_LIM (also increments in DBL).
- Load capture: beat-0 read data → rdata_lo; beat-1 → rdata_hi. mem_rvalid pulses the cycle after a load's mem_done. Stores never pulse mem_rvalid; rdata registers are unchanged for stores and fetches. Single loads leave rdata_hi unchanged.
- port_en = if_grant | mem_grant. The grants are mutually exclusive.

## Timing
- Grants, mem_done, stall_* and port_* are combinational from state and the current-cycle inputs. mem_beat is registered, so no comb loop through mem_wdata.
- Single transfer: latency 0 (done in the request cycle). Double transfer: 2 consecutive cycles, done in the second. mem_rvalid is +1 cycle after done.
- Fetch worst-case wait: STARVE_LIM cycles, plus 1 if the forced slot falls in DBL.
- Reset (sync): state IDLE, mem_beat 0, starve_cnt 0, mem_rvalid 0, rdata_lo/hi 0. While reset is high, all grants, mem_done and port_en are forced 0. Reset during DBL aborts the transfer: beat 1 is never issued and no rvalid follows.
- Simultaneous if_req & mem_req in IDLE: MEM wins unless force_if.
- Address wrap: base all-ones → beat 1 at address 0.

## Test plan
- Reset, then if_req=1, mem_req=0, if_addr=0x10 → if_grant=1, port_addr=0x10, port_we=0, stall_if=0, every cycle.
- Single load, mem_addr=0x20, port_rdata=0xAAAA → grant+done same cycle, stall_mem=0; next cycle mem_rvalid=1, mem_rdata_lo=0xAAAA.
- Double store at 0x40 with concurrent if_req → cycles: port_addr 0x40 (beat 0), then 0x41 (beat 1, done); port_we=1 both; stall_if=1 both; no mem_rvalid.
- Continuous single-load mem_req plus if_req, STARVE_LIM=4 → MEM granted 4 cycles, fetch granted on the 5th, counter cleared, then the pattern repeats.
- Double load at 0xFFFFFFFF → beat addresses 0xFFFFFFFF then 0x0; rdata_lo/hi captured; rvalid 1 cycle after done.
- Reset asserted in DBL cycle → port_en=0 that cycle; next cycle IDLE, mem_beat=0, no mem_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  mem_port_arbiter
//  Shares one memory port between fetch and MEM; sequences 2-beat LDW/SDW.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_double,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_beat,
  output logic              mem_grant,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata_lo,
  output logic [DATA_W-1:0] mem_rdata_hi,
  output logic              mem_rvalid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              port_en,
  output logic              port_we,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  input  logic [DATA_W-1:0] port_rdata
);

  localparam int c_CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIM);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DBL  = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_beat;
  logic                r_dbl_we;
  logic [ADDR_W-1:0]   r_hi_addr;
  logic [c_CNT_W-1:0]  r_starve;
  logic [DATA_W-1:0]   r_rdata_lo;
  logic [DATA_W-1:0]   r_rdata_hi;
  logic                r_rvalid;

  logic w_force_if;
  logic w_if_grant;
  logic w_mem_grant;
  logic w_mem_done;
  logic w_port_we;
  logic [ADDR_W-1:0] w_port_addr;
  logic [DATA_W-1:0] w_port_wdata;

  assign w_force_if = if_req & (r_starve == c_STARVE_MAX);

  always_comb begin
    w_if_grant   = 1'b0;
    w_mem_grant  = 1'b0;
    w_mem_done   = 1'b0;
    w_port_we    = 1'b0;
    w_port_addr  = '0;
    w_port_wdata = '0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req && !w_force_if) begin
            w_mem_grant  = 1'b1;
            w_mem_done   = ~mem_double;
            w_port_we    = mem_we;
            w_port_addr  = mem_addr;
            w_port_wdata = mem_wdata;
          end else if (if_req) begin
            w_if_grant  = 1'b1;
            w_port_addr = if_addr;
          end
        end
        ST_DBL: begin
          // Second beat is indivisible from the first: mem_req/mem_we not re-sampled.
          w_mem_grant  = 1'b1;
          w_mem_done   = 1'b1;
          w_port_we    = r_dbl_we;
          w_port_addr  = r_hi_addr;
          w_port_wdata = mem_wdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_beat     <= 1'b0;
      r_dbl_we   <= 1'b0;
      r_hi_addr  <= '0;
      r_starve   <= '0;
      r_rdata_lo <= '0;
      r_rdata_hi <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      if (w_if_grant || !if_req)
        r_starve <= '0;
      else if (r_starve != c_STARVE_MAX)
        r_starve <= r_starve + 1'b1;

      r_rvalid <= w_mem_done & ~w_port_we;

      case (r_state)
        ST_IDLE: begin
          if (w_mem_grant && !mem_we)
            r_rdata_lo <= port_rdata;
          if (w_mem_grant && mem_double) begin
            r_state   <= ST_DBL;
            r_beat    <= 1'b1;
            r_dbl_we  <= mem_we;
            r_hi_addr <= mem_addr + ADDR_W'(1);
          end
        end
        ST_DBL: begin
          if (!r_dbl_we)
            r_rdata_hi <= port_rdata;
          r_state <= ST_IDLE;
          r_beat  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_grant     = w_if_grant;
  assign mem_grant    = w_mem_grant;
  assign mem_done     = w_mem_done;
  assign mem_beat     = r_beat;
  assign mem_rdata_lo = r_rdata_lo;
  assign mem_rdata_hi = r_rdata_hi;
  assign mem_rvalid   = r_rvalid;
  assign stall_if     = if_req & ~w_if_grant;
  assign stall_mem    = mem_req & ~w_mem_done;
  assign port_en      = w_if_grant | w_mem_grant;
  assign port_we      = w_port_we;
  assign port_addr    = w_port_addr;
  assign port_wdata   = w_port_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  tb_mem_port_arbiter
//  Randomized + directed stimulus against a transaction-level reference model.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int c_LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_grant;
  logic        mem_req, mem_we, mem_double;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_beat, mem_grant, mem_done;
  logic [31:0] mem_rdata_lo, mem_rdata_hi;
  logic        mem_rvalid, stall_if, stall_mem;
  logic        port_en, port_we;
  logic [31:0] port_addr, port_wdata, port_rdata;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign port_rdata = memf(port_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(c_LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
    .mem_req(mem_req), .mem_we(mem_we), .mem_double(mem_double),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_beat(mem_beat), .mem_grant(mem_grant), .mem_done(mem_done),
    .mem_rdata_lo(mem_rdata_lo), .mem_rdata_hi(mem_rdata_hi), .mem_rvalid(mem_rvalid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .port_en(port_en), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_rdata(port_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pending second word of a double transfer, a count of
  // consecutive denied fetch cycles, and the last load data seen.
  bit          m_known = 0;
  bit          m_second;
  bit          m_second_store;
  logic [31:0] m_second_addr;
  int          m_denied;
  logic [31:0] m_lo, m_hi;
  bit          m_rvalid;

  bit          e_done;
  logic [31:0] obs_addr;
  bit          obs_ifg;

  task automatic cycle(input bit rst, input bit ifr, input logic [31:0] ifa,
                       input bit mr, input bit mw, input bit md,
                       input logic [31:0] ma, input logic [31:0] wd0, input logic [31:0] wd1);
    bit e_ifg, e_mg, e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    reset = rst; if_req = ifr; if_addr = ifa;
    mem_req = mr; mem_we = mw; mem_double = md; mem_addr = ma;
    mem_wdata = (m_known && m_second) ? wd1 : wd0;
    #1;
    e_ifg = 0; e_mg = 0; e_done = 0; e_we = 0; e_addr = '0; e_wd = mem_wdata;
    if (!rst) begin
      if (m_known && m_second) begin
        e_mg = 1; e_done = 1; e_we = m_second_store; e_addr = m_second_addr;
      end else if (mr && !(ifr && m_denied == c_LIM)) begin
        e_mg = 1; e_done = !md; e_we = mw; e_addr = ma;
      end else if (ifr) begin
        e_ifg = 1; e_addr = ifa;
      end
    end
    obs_addr = port_addr;
    obs_ifg  = if_grant;
    chk("if_grant",  {63'b0, if_grant},  {63'b0, e_ifg});
    chk("mem_grant", {63'b0, mem_grant}, {63'b0, e_mg});
    chk("mem_done",  {63'b0, mem_done},  {63'b0, e_done});
    chk("port_en",   {63'b0, port_en},   {63'b0, e_ifg | e_mg});
    chk("stall_if",  {63'b0, stall_if},  {63'b0, ifr & ~e_ifg});
    chk("stall_mem", {63'b0, stall_mem}, {63'b0, mr & ~e_done});
    if (e_ifg | e_mg) begin
      chk("port_we",   {63'b0, port_we}, {63'b0, e_we});
      chk("port_addr", {32'b0, port_addr}, {32'b0, e_addr});
      if (e_we) chk("port_wdata", {32'b0, port_wdata}, {32'b0, e_wd});
    end
    if (m_known) begin
      chk("mem_beat",   {63'b0, mem_beat},   {63'b0, m_second});
      chk("mem_rvalid", {63'b0, mem_rvalid}, {63'b0, m_rvalid});
      chk("rdata_lo",   {32'b0, mem_rdata_lo}, {32'b0, m_lo});
      chk("rdata_hi",   {32'b0, mem_rdata_hi}, {32'b0, m_hi});
    end
    // advance the model to the state after the coming rising edge
    if (rst) begin
      m_known = 1; m_second = 0; m_denied = 0; m_lo = '0; m_hi = '0; m_rvalid = 0;
    end else if (m_known) begin
      m_denied = (e_ifg || !ifr) ? 0 : ((m_denied < c_LIM) ? m_denied + 1 : c_LIM);
      m_rvalid = e_done && !e_we;
      if (m_second) begin
        if (!e_we) m_hi = memf(e_addr);
        m_second = 0;
      end else if (e_mg) begin
        if (!e_we) m_lo = memf(e_addr);
        if (md) begin
          m_second = 1; m_second_store = mw; m_second_addr = ma + 32'd1;
        end
      end
    end
  endtask

  initial begin
    bit busy, bw, bd;
    logic [31:0] ba, b0, b1;
    bit pat_ok;
    busy = 0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h10, 1, 0, 0, 32'h20, 0, 0);
    chk("rst_port_en", {63'b0, port_en}, 64'd0);

    // fetch only
    repeat (3) begin
      cycle(0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
      chk("fetch_addr", {32'b0, obs_addr}, 64'h10);
    end

    // single load
    cycle(0, 0, 0, 1, 0, 0, 32'h20, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sl_lo", {32'b0, mem_rdata_lo}, {32'b0, memf(32'h20)});

    // double store with concurrent fetch
    cycle(0, 1, 32'h100, 1, 1, 1, 32'h40, 32'hD0, 32'hD1);
    chk("ds_b0_addr", {32'b0, obs_addr}, 64'h40);
    cycle(0, 1, 32'h100, 1, 1, 1, 32'h40, 32'hD0, 32'hD1);
    chk("ds_b1_addr", {32'b0, obs_addr}, 64'h41);

    // starvation: expect fetch on every 5th cycle
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pat_ok = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 32'h200, 1, 0, 0, 32'h300 + i, 0, 0);
      if (obs_ifg != ((i % 5) == 4)) pat_ok = 0;
    end
    chk("starve_pattern", {63'b0, pat_ok}, 64'd1);

    // double load across the address wrap
    cycle(0, 0, 0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0);
    chk("wrap_b0", {32'b0, obs_addr}, 64'hFFFF_FFFF);
    cycle(0, 0, 0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0);
    chk("wrap_b1", {32'b0, obs_addr}, 64'h0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_rvalid", {63'b0, mem_rvalid}, 64'd1);
    chk("wrap_hi", {32'b0, mem_rdata_hi}, {32'b0, memf(32'h0)});

    // reset landing on the second beat
    cycle(0, 0, 0, 1, 0, 1, 32'h500, 0, 0);
    cycle(1, 0, 0, 1, 0, 1, 32'h500, 0, 0);
    chk("rst_dbl_en", {63'b0, port_en}, 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_dbl_beat", {63'b0, mem_beat}, 64'd0);
    chk("rst_dbl_rvalid", {63'b0, mem_rvalid}, 64'd0);

    // random traffic; MEM requests are held until done
    for (int n = 0; n < 1500; n++) begin
      bit rst;
      rst = ($urandom_range(0, 99) < 2);
      if (!busy && $urandom_range(0, 99) < 60) begin
        busy = 1;
        bw = $urandom_range(0, 1);
        bd = $urandom_range(0, 1);
        ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b0 = $urandom; b1 = $urandom;
      end
      cycle(rst, ($urandom_range(0, 99) < 70), $urandom, busy, bw, bd, ba, b0, b1);
      if (rst || e_done) busy = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
